// File: rtl/komandara_axi4lite_cmd_arbiter.sv
// Shares one AXI4-Lite master cmd/rsp port between NUM_REQ requesters, one transaction at a time.
// Round-robin by default; define KOMANDARA_AXI_ARB_FIXED_PRIO_EN for fixed lowest-index priority.
module komandara_axi4lite_cmd_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    localparam int IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NUM_REQ-1:0]             s_cmd_valid_i,
    output logic [NUM_REQ-1:0]             s_cmd_ready_o,
    input  logic [NUM_REQ-1:0]             s_cmd_write_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  s_cmd_addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  s_cmd_wdata_i,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0] s_cmd_wstrb_i,
    input  logic [NUM_REQ*3-1:0]           s_cmd_prot_i,
    output logic [NUM_REQ-1:0]             s_rsp_valid_o,
    input  logic [NUM_REQ-1:0]             s_rsp_ready_i,
    output logic [DATA_WIDTH-1:0]          s_rsp_rdata_o,
    output logic [1:0]                     s_rsp_resp_o,
    output logic                           m_cmd_valid_o,
    input  logic                           m_cmd_ready_i,
    output logic                           m_cmd_write_o,
    output logic [ADDR_WIDTH-1:0]          m_cmd_addr_o,
    output logic [DATA_WIDTH-1:0]          m_cmd_wdata_o,
    output logic [DATA_WIDTH/8-1:0]        m_cmd_wstrb_o,
    output logic [2:0]                     m_cmd_prot_o,
    input  logic                           m_rsp_valid_i,
    output logic                           m_rsp_ready_o,
    input  logic [DATA_WIDTH-1:0]          m_rsp_rdata_i,
    input  logic [1:0]                     m_rsp_resp_i,
    output logic                           busy_o,
    output logic [IDX_W-1:0]               grant_idx_o
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int PROT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_RSP  = 2'd2
    } state_e;

    state_e            state_r, state_s;
    logic [IDX_W-1:0]  grant_r, grant_s;
    logic [IDX_W-1:0]  winner_s;
    logic [IDX_W-1:0]  base_s;
    logic              grant_valid_s;
    logic              rsp_done_s;
    int unsigned       grant_int_s;

    assign grant_int_s   = 32'(grant_r);
    assign grant_valid_s = s_cmd_valid_i[grant_r];
    assign rsp_done_s    = (state_r == ST_RSP) && m_rsp_valid_i && s_rsp_ready_i[grant_r];

`ifdef KOMANDARA_AXI_ARB_FIXED_PRIO_EN
    assign base_s = '0;
`else
    logic [IDX_W-1:0] rr_ptr_r;

    // Round-robin pointer: the search starts just after the last requester served.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_r <= '0;
        end else if (rsp_done_s) begin
            rr_ptr_r <= (grant_r == IDX_W'(NUM_REQ - 1)) ? '0 : grant_r + 1'b1;
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    assign base_s = rr_ptr_r;
`endif

    // Winner search: first valid requester starting at base_s, wrapping modulo NUM_REQ.
    always_comb begin
        int   sum_v;
        int   idx_v;
        logic found_v;
        winner_s = '0;
        found_v  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum_v = int'(base_s) + k;
            idx_v = (sum_v >= NUM_REQ) ? (sum_v - NUM_REQ) : sum_v;
            if (!found_v && s_cmd_valid_i[idx_v]) begin
                winner_s = IDX_W'(idx_v);
                found_v  = 1'b1;
            end else begin
                found_v  = found_v;
            end
        end
    end

    // FSM next state and the per-state handshake steering.
    always_comb begin
        state_s       = state_r;
        grant_s       = grant_r;
        m_cmd_valid_o = 1'b0;
        m_rsp_ready_o = 1'b0;
        s_cmd_ready_o = '0;
        s_rsp_valid_o = '0;
        case (state_r)
            ST_IDLE: begin
                if (|s_cmd_valid_i) begin
                    grant_s = winner_s;
                    state_s = ST_CMD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CMD: begin
                m_cmd_valid_o          = grant_valid_s;
                s_cmd_ready_o[grant_r] = m_cmd_ready_i;
                if (grant_valid_s && m_cmd_ready_i) begin
                    state_s = ST_RSP;
                end else if (!grant_valid_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_CMD;
                end
            end
            ST_RSP: begin
                s_rsp_valid_o[grant_r] = m_rsp_valid_i;
                m_rsp_ready_o          = s_rsp_ready_i[grant_r];
                if (rsp_done_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RSP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and grant registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
            grant_r <= '0;
        end else begin
            state_r <= state_s;
            grant_r <= grant_s;
        end
    end

    assign m_cmd_write_o = s_cmd_write_i[grant_r];
    assign m_cmd_addr_o  = s_cmd_addr_i[grant_int_s*ADDR_WIDTH +: ADDR_WIDTH];
    assign m_cmd_wdata_o = s_cmd_wdata_i[grant_int_s*DATA_WIDTH +: DATA_WIDTH];
    assign m_cmd_wstrb_o = s_cmd_wstrb_i[grant_int_s*STRB_W +: STRB_W];
    assign m_cmd_prot_o  = s_cmd_prot_i[grant_int_s*PROT_W +: PROT_W];
    assign s_rsp_rdata_o = m_rsp_rdata_i;
    assign s_rsp_resp_o  = m_rsp_resp_i;
    assign busy_o        = (state_r != ST_IDLE);
    assign grant_idx_o   = grant_r;

    komandara_axi4lite_cmd_arbiter_chk #(
        .NUM_REQ (NUM_REQ)
    ) u_chk (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cmd_phase   (state_r == ST_CMD),
        .grant_valid (grant_valid_s),
        .cmd_ready   (s_cmd_ready_o),
        .rsp_valid   (s_rsp_valid_o)
    );
endmodule

// Protocol checks for the arbiter; simulation-only properties.
module komandara_axi4lite_cmd_arbiter_chk #(
    parameter int NUM_REQ = 2
) (
    input logic               clk_i,
    input logic               rst_i,
    input logic               cmd_phase,
    input logic               grant_valid,
    input logic [NUM_REQ-1:0] cmd_ready,
    input logic [NUM_REQ-1:0] rsp_valid
);
    a_cmd_valid_held: assert property (@(posedge clk_i) disable iff (rst_i) cmd_phase |-> grant_valid)
        else $error("granted requester dropped cmd valid before handshake");
    a_cmd_ready_onehot: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(cmd_ready))
        else $error("more than one s_cmd_ready_o bit high");
    a_rsp_valid_onehot: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(rsp_valid))
        else $error("more than one s_rsp_valid_o bit high");
endmodule

// File: tb/tb_komandara_axi4lite_cmd_arbiter.sv
// Directed bench for komandara_axi4lite_cmd_arbiter with three requesters.
module tb_komandara_axi4lite_cmd_arbiter;
    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [N-1:0]     s_cmd_valid, s_cmd_ready, s_cmd_write, s_rsp_valid, s_rsp_ready;
    logic [N*AW-1:0]  s_cmd_addr;
    logic [N*DW-1:0]  s_cmd_wdata;
    logic [N*SW-1:0]  s_cmd_wstrb;
    logic [N*3-1:0]   s_cmd_prot;
    logic [DW-1:0]    s_rsp_rdata;
    logic [1:0]       s_rsp_resp;
    logic             m_cmd_valid, m_cmd_ready, m_cmd_write;
    logic [AW-1:0]    m_cmd_addr;
    logic [DW-1:0]    m_cmd_wdata;
    logic [SW-1:0]    m_cmd_wstrb;
    logic [2:0]       m_cmd_prot;
    logic             m_rsp_valid, m_rsp_ready;
    logic [DW-1:0]    m_rsp_rdata;
    logic [1:0]       m_rsp_resp;
    logic             busy;
    logic [1:0]       grant_idx;

    int total = 0;
    int bad   = 0;
    int gcnt [N];

    komandara_axi4lite_cmd_arbiter #(
        .NUM_REQ    (N),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .s_cmd_valid_i (s_cmd_valid),
        .s_cmd_ready_o (s_cmd_ready),
        .s_cmd_write_i (s_cmd_write),
        .s_cmd_addr_i  (s_cmd_addr),
        .s_cmd_wdata_i (s_cmd_wdata),
        .s_cmd_wstrb_i (s_cmd_wstrb),
        .s_cmd_prot_i  (s_cmd_prot),
        .s_rsp_valid_o (s_rsp_valid),
        .s_rsp_ready_i (s_rsp_ready),
        .s_rsp_rdata_o (s_rsp_rdata),
        .s_rsp_resp_o  (s_rsp_resp),
        .m_cmd_valid_o (m_cmd_valid),
        .m_cmd_ready_i (m_cmd_ready),
        .m_cmd_write_o (m_cmd_write),
        .m_cmd_addr_o  (m_cmd_addr),
        .m_cmd_wdata_o (m_cmd_wdata),
        .m_cmd_wstrb_o (m_cmd_wstrb),
        .m_cmd_prot_o  (m_cmd_prot),
        .m_rsp_valid_i (m_rsp_valid),
        .m_rsp_ready_o (m_rsp_ready),
        .m_rsp_rdata_i (m_rsp_rdata),
        .m_rsp_resp_i  (m_rsp_resp),
        .busy_o        (busy),
        .grant_idx_o   (grant_idx)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_outputs(input string tag);
        check({tag, "_cmd_ready"}, 64'(s_cmd_ready), 64'd0);
        check({tag, "_rsp_valid"}, 64'(s_rsp_valid), 64'd0);
        check({tag, "_m_cmd_valid"}, 64'(m_cmd_valid), 64'd0);
        check({tag, "_m_rsp_ready"}, 64'(m_rsp_ready), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_grant"}, 64'(grant_idx), 64'd0);
    endtask

    initial begin
        int e;
        rst = 1'b1;
        s_cmd_valid = '0; s_cmd_write = '0; s_rsp_ready = '0;
        s_cmd_addr = '0; s_cmd_wdata = '0; s_cmd_wstrb = '0; s_cmd_prot = '0;
        m_cmd_ready = 1'b0; m_rsp_valid = 1'b0; m_rsp_rdata = '0; m_rsp_resp = 2'd0;
        for (int i = 0; i < N; i++) gcnt[i] = 0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        idle_outputs("reset");

        // Single request from requester 1
        s_cmd_valid = 3'b010;
        s_cmd_write = 3'b010;
        s_cmd_addr[1*AW +: AW]  = 32'h0000_1000;
        s_cmd_wdata[1*DW +: DW] = 32'hDEAD_BEEF;
        s_cmd_wstrb[1*SW +: SW] = 4'hF;
        s_cmd_prot[1*3 +: 3]    = 3'b010;
        #1;
        check("single_c0_mvalid", 64'(m_cmd_valid), 64'd0);
        tick();
        check("single_mvalid", 64'(m_cmd_valid), 64'd1);
        check("single_grant", 64'(grant_idx), 64'd1);
        check("single_addr", 64'(m_cmd_addr), 64'h1000);
        check("single_wdata", 64'(m_cmd_wdata), 64'hDEADBEEF);
        check("single_wstrb", 64'(m_cmd_wstrb), 64'hF);
        check("single_write", 64'(m_cmd_write), 64'd1);
        check("single_prot", 64'(m_cmd_prot), 64'd2);
        check("single_busy", 64'(busy), 64'd1);
        check("single_sready_stall", 64'(s_cmd_ready), 64'd0);
        m_cmd_ready = 1'b1;
        #1;
        check("single_sready", 64'(s_cmd_ready), 64'b010);
        tick();
        s_cmd_valid = '0; m_cmd_ready = 1'b0;
        m_rsp_valid = 1'b1; m_rsp_resp = 2'd0; s_rsp_ready = 3'b010;
        #1;
        check("single_rsp_valid", 64'(s_rsp_valid), 64'b010);
        check("single_rsp_resp", 64'(s_rsp_resp), 64'd0);
        check("single_m_rsp_ready", 64'(m_rsp_ready), 64'd1);
        tick();
        m_rsp_valid = 1'b0; s_rsp_ready = '0;
        #1;
        check("single_done_busy", 64'(busy), 64'd0);

        // Round-robin with all requesters continuously valid
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < N; i++) s_cmd_addr[i*AW +: AW] = 32'((i + 1) * 256);
        s_cmd_valid = 3'b111;
        for (int t = 0; t < 6; t++) begin
`ifdef KOMANDARA_AXI_ARB_FIXED_PRIO_EN
            e = 0;
`else
            e = t % N;
`endif
            tick();
            check($sformatf("rr%0d_grant", t), 64'(grant_idx), 64'(e));
            check($sformatf("rr%0d_addr", t), 64'(m_cmd_addr), 64'((e + 1) * 256));
            if (grant_idx < 2'(N)) gcnt[grant_idx]++;
            m_cmd_ready = 1'b1;
            #1;
            check($sformatf("rr%0d_sready", t), 64'(s_cmd_ready), 64'(1 << e));
            tick();
            m_cmd_ready = 1'b0; m_rsp_valid = 1'b1; s_rsp_ready = 3'b111;
            #1;
            check($sformatf("rr%0d_rsp_valid", t), 64'(s_rsp_valid), 64'(1 << e));
            tick();
            m_rsp_valid = 1'b0; s_rsp_ready = '0;
        end
        for (int i = 0; i < N; i++) begin
`ifdef KOMANDARA_AXI_ARB_FIXED_PRIO_EN
            check($sformatf("rr_count%0d", i), 64'(gcnt[i]), (i == 0) ? 64'd6 : 64'd0);
`else
            check($sformatf("rr_count%0d", i), 64'(gcnt[i]), 64'd2);
`endif
        end

        // Response isolation: requester 0 read held off by its own ready
        s_cmd_valid = 3'b001; s_cmd_write = 3'b000;
        s_cmd_addr[0*AW +: AW] = 32'h20;
        tick();
        check("iso_grant0", 64'(grant_idx), 64'd0);
        check("iso_addr", 64'(m_cmd_addr), 64'h20);
        m_cmd_ready = 1'b1;
        tick();
        m_cmd_ready = 1'b0;
        s_cmd_valid = 3'b100;
        s_cmd_write = 3'b100;
        s_cmd_addr[2*AW +: AW]  = 32'h3000;
        s_cmd_wdata[2*DW +: DW] = 32'hCAFE_F00D;
        m_rsp_valid = 1'b1; m_rsp_rdata = 32'h1234_5678; m_rsp_resp = 2'd0;
        for (int c = 0; c < 4; c++) begin
            #1;
            check($sformatf("iso%0d_rsp_valid", c), 64'(s_rsp_valid), 64'b001);
            check($sformatf("iso%0d_m_rsp_ready", c), 64'(m_rsp_ready), 64'd0);
            check($sformatf("iso%0d_sready2", c), 64'(s_cmd_ready), 64'd0);
            check($sformatf("iso%0d_rdata", c), 64'(s_rsp_rdata), 64'h12345678);
            tick();
        end
        s_rsp_ready = 3'b001;
        #1;
        check("iso_release_m_rsp_ready", 64'(m_rsp_ready), 64'd1);
        tick();
        m_rsp_valid = 1'b0; s_rsp_ready = '0;
        tick();
        check("iso_grant2", 64'(grant_idx), 64'd2);

        // Downstream stall: command held stable while m_cmd_ready is low
        for (int c = 0; c < 5; c++) begin
            check($sformatf("stall%0d_mvalid", c), 64'(m_cmd_valid), 64'd1);
            check($sformatf("stall%0d_addr", c), 64'(m_cmd_addr), 64'h3000);
            check($sformatf("stall%0d_wdata", c), 64'(m_cmd_wdata), 64'hCAFEF00D);
            tick();
        end
        m_cmd_ready = 1'b1;
        #1;
        check("stall_sready", 64'(s_cmd_ready), 64'b100);
        tick();
        m_cmd_ready = 1'b0; m_rsp_valid = 1'b1;
        #1;
        check("stall_rsp_mvalid", 64'(m_cmd_valid), 64'd0);
        check("stall_rsp_valid", 64'(s_rsp_valid), 64'b100);

        // Reset while in the response phase
        rst = 1'b1;
        s_cmd_valid = 3'b011;
        tick();
        idle_outputs("midrst");
        rst = 1'b0; m_rsp_valid = 1'b0;
        tick();
        check("midrst_next_grant", 64'(grant_idx), 64'd0);
        check("midrst_next_mvalid", 64'(m_cmd_valid), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
